data_island_scheduler: RTL

Owns the pixel raster and sequences every HDMI transmission period on the `clk_pixel` domain. It generates the raster counters and the per-pixel period mode: control, video preamble/guard/active, island preamble/guard/data. It also drives `packet_enable`, `packet_pixel_counter` and `video_field_end` into the packet selection logic. The TMDS encoders sit downstream and consume `mode`.

---
 rtl/hdmi_timing_pkg.sv | 32 +++
 rtl/raster_counter.sv | 44 ++++
 rtl/data_island_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hdmi_timing_pkg.sv
// rtl/hdmi_timing_pkg.sv - shared HDMI period modes and period lengths
package hdmi_timing_pkg;

    typedef enum logic [2:0] {
        MODE_CONTROL         = 3'd0,
        MODE_VIDEO_PREAMBLE  = 3'd1,
        MODE_VIDEO_GUARD     = 3'd2,
        MODE_VIDEO           = 3'd3,
        MODE_ISLAND_PREAMBLE = 3'd4,
        MODE_ISLAND_GUARD    = 3'd5,
        MODE_ISLAND_DATA     = 3'd6
    } mode_t;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;
    localparam int CTL_LEAD     = 4;
    localparam int CTL_MIN_GAP  = 12;

    // Blanking pixels consumed by everything in a line except the packets themselves.
    localparam int BLANK_OVERHEAD = CTL_LEAD + PREAMBLE_LEN + 2 * GUARD_LEN + CTL_MIN_GAP
                                  + PREAMBLE_LEN + GUARD_LEN;

    function automatic int packets_per_island(input int frame_width, input int screen_width,
                                              input int max_packets);
        int fit;
        fit = (frame_width - screen_width - BLANK_OVERHEAD) / PACKET_LEN;
        if (fit < 0) fit = 0;
        return (fit < max_packets) ? fit : max_packets;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - pixel/line counters with a registered end-of-frame flag
module raster_counter #(
    parameter int FRAME_WIDTH  = 858,
    parameter int SCREEN_WIDTH = 720,
    parameter int FRAME_HEIGHT = 525,
    parameter int BIT_WIDTH    = $clog2(FRAME_WIDTH),
    parameter int BIT_HEIGHT   = $clog2(FRAME_HEIGHT)
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    output logic [BIT_WIDTH-1:0]  cx,
    output logic [BIT_HEIGHT-1:0] cy,
    output logic                  frame_end
);

    localparam logic [BIT_WIDTH-1:0]  LAST_X = BIT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [BIT_HEIGHT-1:0] LAST_Y = BIT_HEIGHT'(FRAME_HEIGHT - 1);

    logic [BIT_WIDTH-1:0]  cx_next;
    logic [BIT_HEIGHT-1:0] cy_next;
    logic                  line_end;

    assign line_end = (cx == LAST_X);

    always_comb begin
        cx_next = line_end ? '0 : cx + 1'b1;
        cy_next = cy;
        if (line_end) cy_next = (cy == LAST_Y) ? '0 : cy + 1'b1;
    end

    // frame_end is computed from the next position so it lines up with the registered cx/cy.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cx        <= BIT_WIDTH'(SCREEN_WIDTH);
            cy        <= LAST_Y;
            frame_end <= 1'b0;
        end else begin
            cx        <= cx_next;
            cy        <= cy_next;
            frame_end <= (cx_next == LAST_X) && (cy_next == LAST_Y);
        end
    end

endmodule

// File: rtl/data_island_scheduler.sv
// rtl/data_island_scheduler.sv - HDMI period sequencer: raster, video and data island timing
module data_island_scheduler
    import hdmi_timing_pkg::*;
#(
    parameter int FRAME_WIDTH   = 858,
    parameter int SCREEN_WIDTH  = 720,
    parameter int FRAME_HEIGHT  = 525,
    parameter int SCREEN_HEIGHT = 480,
    parameter int MAX_PACKETS   = 18,
    parameter int BIT_WIDTH     = $clog2(FRAME_WIDTH),
    parameter int BIT_HEIGHT    = $clog2(FRAME_HEIGHT)
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic                  island_enable,
    output logic [BIT_WIDTH-1:0]  cx,
    output logic [BIT_HEIGHT-1:0] cy,
    output logic [2:0]            mode,
    output logic                  packet_enable,
    output logic [4:0]            packet_pixel_counter,
    output logic                  video_field_end
);

    localparam int  S          = SCREEN_WIDTH + CTL_LEAD;
    localparam int  N          = packets_per_island(FRAME_WIDTH, SCREEN_WIDTH, MAX_PACKETS);
    localparam bit  ISLANDS_ON = (N > 0);
    localparam int  LEN_W      = $clog2(PACKET_LEN * MAX_PACKETS + PREAMBLE_LEN + 1);

    localparam logic [BIT_WIDTH-1:0]  X_ISL_ARM = BIT_WIDTH'(S - 1);
    localparam logic [BIT_WIDTH-1:0]  X_VID_ARM = BIT_WIDTH'(FRAME_WIDTH - PREAMBLE_LEN - GUARD_LEN - 1);
    localparam logic [BIT_WIDTH-1:0]  X_VID_END = BIT_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [BIT_HEIGHT-1:0] Y_PRE_END = BIT_HEIGHT'(SCREEN_HEIGHT - 1);
    localparam logic [BIT_HEIGHT-1:0] Y_LAST    = BIT_HEIGHT'(FRAME_HEIGHT - 1);

    localparam logic [LEN_W-1:0] PRE_LEN  = LEN_W'(PREAMBLE_LEN - 1);
    localparam logic [LEN_W-1:0] GB_LEN   = LEN_W'(GUARD_LEN - 1);
    localparam logic [LEN_W-1:0] DATA_LEN = LEN_W'(PACKET_LEN * N - 1);
    localparam logic [LEN_W-1:0] PKT_LEN  = LEN_W'(PACKET_LEN);

    typedef enum logic [2:0] {
        ST_CTL, ST_ISL_PRE, ST_ISL_LGB, ST_ISL_DATA, ST_ISL_TGB, ST_VID_PRE, ST_VID_GB, ST_VIDEO
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic             next_line_active;

    raster_counter #(
        .FRAME_WIDTH  (FRAME_WIDTH),
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT),
        .BIT_WIDTH    (BIT_WIDTH),
        .BIT_HEIGHT   (BIT_HEIGHT)
    ) u_raster (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .cx        (cx),
        .cy        (cy),
        .frame_end (video_field_end)
    );

    assign next_line_active = (cy < Y_PRE_END) || (cy == Y_LAST);

    // Each branch decides the period of the pixel presented next, so mode tracks cx exactly.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state                <= ST_CTL;
            len                  <= '0;
            mode                 <= MODE_CONTROL;
            packet_enable        <= 1'b0;
            packet_pixel_counter <= 5'd0;
        end else begin
            packet_enable        <= 1'b0;
            packet_pixel_counter <= 5'd0;
            case (state)
                ST_CTL: begin
                    if (cx == X_ISL_ARM && island_enable && ISLANDS_ON) begin
                        state <= ST_ISL_PRE;
                        len   <= PRE_LEN;
                        mode  <= MODE_ISLAND_PREAMBLE;
                    end else if (cx == X_VID_ARM && next_line_active) begin
                        state <= ST_VID_PRE;
                        len   <= PRE_LEN;
                        mode  <= MODE_VIDEO_PREAMBLE;
                    end
                end
                ST_ISL_PRE: begin
                    if (len == '0) begin
                        state <= ST_ISL_LGB;
                        len   <= GB_LEN;
                        mode  <= MODE_ISLAND_GUARD;
                    end else begin
                        len <= len - 1'b1;
                    end
                end
                ST_ISL_LGB: begin
                    if (len == '0) begin
                        state <= ST_ISL_DATA;
                        len   <= DATA_LEN;
                        mode  <= MODE_ISLAND_DATA;
                    end else begin
                        len           <= len - 1'b1;
                        packet_enable <= (len == LEN_W'(1));
                    end
                end
                ST_ISL_DATA: begin
                    if (len == '0) begin
                        state <= ST_ISL_TGB;
                        len   <= GB_LEN;
                        mode  <= MODE_ISLAND_GUARD;
                    end else begin
                        len                  <= len - 1'b1;
                        packet_pixel_counter <= packet_pixel_counter + 5'd1;
                        // Strobe ahead of the next packet only while a whole packet still remains.
                        packet_enable        <= (packet_pixel_counter == 5'd30) && (len > PKT_LEN);
                    end
                end
                ST_ISL_TGB: begin
                    if (len == '0) begin
                        state <= ST_CTL;
                        mode  <= MODE_CONTROL;
                    end else begin
                        len <= len - 1'b1;
                    end
                end
                ST_VID_PRE: begin
                    if (len == '0) begin
                        state <= ST_VID_GB;
                        len   <= GB_LEN;
                        mode  <= MODE_VIDEO_GUARD;
                    end else begin
                        len <= len - 1'b1;
                    end
                end
                ST_VID_GB: begin
                    if (len == '0) begin
                        state <= ST_VIDEO;
                        mode  <= MODE_VIDEO;
                    end else begin
                        len <= len - 1'b1;
                    end
                end
                ST_VIDEO: begin
                    if (cx == X_VID_END) begin
                        state <= ST_CTL;
                        mode  <= MODE_CONTROL;
                    end
                end
                default: begin
                    state <= ST_CTL;
                    mode  <= MODE_CONTROL;
                end
            endcase
        end
    end

endmodule
